// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multicycle RV32IM core: state codes, ALU opcodes,
// base opcodes and datapath mux selects.
package multi_cycle_control_pkg;

  typedef enum logic [5:0] {
    ST_FETCH     = 6'd0,
    ST_DECODE    = 6'd1,
    ST_LS_ADDR   = 6'd2,
    ST_LOAD_MEM  = 6'd3,
    ST_LOAD_WB   = 6'd4,
    ST_STORE_MEM = 6'd5,
    ST_R_EX      = 6'd6,
    ST_ALU_WB    = 6'd7,
    ST_I_EX      = 6'd8,
    ST_BRANCH    = 6'd9,
    ST_JAL       = 6'd10,
    ST_JALR      = 6'd11,
    ST_LUI_EX    = 6'd12,
    ST_ECALL     = 6'd14,
    ST_URET      = 6'd15,
    ST_CSR_EX    = 6'd16,
    ST_CSR_WB    = 6'd17,
    ST_INVALID   = 6'd18
  } state_t;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] AULA_A      = 3'b000;
  localparam logic [2:0] AULA_PC     = 3'b001;
  localparam logic [2:0] AULA_PCBACK = 3'b010;
  localparam logic [2:0] AULA_NOT_A  = 3'b100;
  localparam logic [2:0] AULA_ZERO   = 3'b101;

  localparam logic [2:0] BULA_B    = 3'b000;
  localparam logic [2:0] BULA_FOUR = 3'b001;
  localparam logic [2:0] BULA_IMM  = 3'b010;
  localparam logic [2:0] BULA_CSR  = 3'b011;
  localparam logic [2:0] BULA_ZERO = 3'b100;

  localparam logic [2:0] M2R_ALUOUT = 3'b000;
  localparam logic [2:0] M2R_PC4    = 3'b001;
  localparam logic [2:0] M2R_MEM    = 3'b010;
  localparam logic [2:0] M2R_CSR    = 3'b100;

  localparam logic [2:0] PC_ALU    = 3'b000;
  localparam logic [2:0] PC_ALUOUT = 3'b001;
  localparam logic [2:0] PC_JALR   = 3'b010;
  localparam logic [2:0] PC_UTVEC  = 3'b011;
  localparam logic [2:0] PC_UEPC   = 3'b100;

  // funct3 -> ALU op for the funct7=0000000 group of OP / OP-IMM
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_alu_op_decode.sv
// Combinational funct3/funct7/opcode decode to an ALU op, plus a flag that
// is low for encodings the core does not implement.
module alu_op_decode
  import multi_cycle_control_pkg::*;
#(
  parameter bit P_HAS_M = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_op = base_alu_op(funct3);
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  alu_op = ALU_SUB;
            3'b101:  alu_op = ALU_SRA;
            default: valid  = 1'b0;
          endcase
        end else if (P_HAS_M && funct7 == F7_MULDIV) begin
          // MUL..REMU are laid out in funct3 order
          alu_op = ALU_MUL + {2'b00, funct3};
        end else begin
          valid = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        alu_op = base_alu_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          valid = 1'b0;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       alu_op = ALU_SRA;
          else if (funct7 != F7_BASE) valid  = 1'b0;
        end
      end
      OPC_LOAD:   valid = !(funct3 inside {3'd3, 3'd6, 3'd7});
      OPC_STORE:  valid = (funct3 < 3'd3);
      OPC_BRANCH: valid = !(funct3 inside {3'd2, 3'd3});
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the RV32IM/Zicsr multicycle datapath; every output
// depends only on the current state and the latched instruction.
//   0 FETCH   1 DECODE   2 LS_ADDR  3 LOAD_MEM  4 LOAD_WB  5 STORE_MEM
//   6 R_EX    7 ALU_WB   8 I_EX     9 BRANCH   10 JAL     11 JALR
//  12 LUI_EX 14 ECALL   15 URET    16 CSR_EX   17 CSR_WB  18 INVALID
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter bit P_HAS_M = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  output logic [5:0]  oState,
  output logic        oEscreveIR,
  output logic        oEscrevePC,
  output logic        oEscrevePCCond,
  output logic        oEscrevePCBack,
  output logic [2:0]  oOrigAULA,
  output logic [2:0]  oOrigBULA,
  output logic [2:0]  oMem2Reg,
  output logic [2:0]  oOrigPC,
  output logic        oIouD,
  output logic        oRegWrite,
  output logic        oCSRegWrite,
  output logic        oMemWrite,
  output logic        oMemRead,
  output logic [4:0]  oALUControl,
  output logic        oEcall,
  output logic        oInvInstruction,
  output logic        oInstrRetired
);

  state_t      state, state_nxt, sys_nxt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [11:0] imm12;
  logic [4:0]  dec_alu_op;
  logic        dec_valid;
  logic        unused_reg_fields;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];
  assign imm12  = iInstr[31:20];
  assign unused_reg_fields = ^{iInstr[19:15], iInstr[11:7]};
  assign oState = state;

  alu_op_decode #(.P_HAS_M(P_HAS_M)) u_alu_op_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    sys_nxt = ST_INVALID;
    if (funct3 == 3'b000) begin
      if (imm12 == 12'h000)      sys_nxt = ST_ECALL;
      else if (imm12 == 12'h002) sys_nxt = ST_URET;
    end else if (funct3 inside {3'b001, 3'b010, 3'b011}) begin
      sys_nxt = ST_CSR_EX;
    end
  end

  always_comb begin
    state_nxt       = ST_FETCH;
    oEscreveIR      = 1'b0;
    oEscrevePC      = 1'b0;
    oEscrevePCCond  = 1'b0;
    oEscrevePCBack  = 1'b0;
    oOrigAULA       = AULA_A;
    oOrigBULA       = BULA_B;
    oMem2Reg        = M2R_ALUOUT;
    oOrigPC         = PC_ALU;
    oIouD           = 1'b0;
    oRegWrite       = 1'b0;
    oCSRegWrite     = 1'b0;
    oMemWrite       = 1'b0;
    oMemRead        = 1'b0;
    oALUControl     = ALU_ADD;
    oEcall          = 1'b0;
    oInvInstruction = 1'b0;
    oInstrRetired   = 1'b0;
    case (state)
      ST_FETCH: begin
        oMemRead       = 1'b1;
        oEscreveIR     = 1'b1;
        oEscrevePCBack = 1'b1;
        oOrigAULA      = AULA_PC;
        oOrigBULA      = BULA_FOUR;
        oEscrevePC     = 1'b1;
        state_nxt      = ST_DECODE;
      end
      ST_DECODE: begin
        // ALUOut <= PCBack + imm, the target for branch/jal/auipc
        oOrigAULA = AULA_PCBACK;
        oOrigBULA = BULA_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = dec_valid ? ST_LS_ADDR : ST_INVALID;
          OPC_OP:              state_nxt = dec_valid ? ST_R_EX    : ST_INVALID;
          OPC_OP_IMM:          state_nxt = dec_valid ? ST_I_EX    : ST_INVALID;
          OPC_BRANCH:          state_nxt = dec_valid ? ST_BRANCH  : ST_INVALID;
          OPC_LUI:             state_nxt = ST_LUI_EX;
          OPC_AUIPC:           state_nxt = ST_ALU_WB;
          OPC_JAL:             state_nxt = ST_JAL;
          OPC_JALR:            state_nxt = ST_JALR;
          OPC_MISC_MEM: begin
            state_nxt     = ST_FETCH;
            oInstrRetired = 1'b1;
          end
          OPC_SYSTEM:          state_nxt = sys_nxt;
          default:             state_nxt = ST_INVALID;
        endcase
      end
      ST_LS_ADDR: begin
        oOrigAULA = AULA_A;
        oOrigBULA = BULA_IMM;
        state_nxt = (opcode == OPC_LOAD) ? ST_LOAD_MEM : ST_STORE_MEM;
      end
      ST_LOAD_MEM: begin
        oIouD     = 1'b1;
        oMemRead  = 1'b1;
        state_nxt = ST_LOAD_WB;
      end
      ST_LOAD_WB: begin
        oMem2Reg      = M2R_MEM;
        oRegWrite     = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_STORE_MEM: begin
        oIouD         = 1'b1;
        oMemWrite     = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_R_EX: begin
        oALUControl = dec_alu_op;
        state_nxt   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        oRegWrite     = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_I_EX: begin
        oOrigBULA   = BULA_IMM;
        oALUControl = dec_alu_op;
        state_nxt   = ST_ALU_WB;
      end
      ST_BRANCH: begin
        oEscrevePCCond = 1'b1;
        oOrigPC        = PC_ALUOUT;
        oInstrRetired  = 1'b1;
      end
      ST_JAL: begin
        oMem2Reg      = M2R_PC4;
        oRegWrite     = 1'b1;
        oOrigPC       = PC_ALUOUT;
        oEscrevePC    = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_JALR: begin
        oOrigBULA     = BULA_IMM;
        oOrigPC       = PC_JALR;
        oMem2Reg      = M2R_PC4;
        oRegWrite     = 1'b1;
        oEscrevePC    = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_LUI_EX: begin
        oOrigAULA = AULA_ZERO;
        oOrigBULA = BULA_IMM;
        state_nxt = ST_ALU_WB;
      end
      ST_ECALL: begin
        oEcall        = 1'b1;
        oOrigPC       = PC_UTVEC;
        oEscrevePC    = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_URET: begin
        oOrigPC       = PC_UEPC;
        oEscrevePC    = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_CSR_EX: begin
        state_nxt = ST_CSR_WB;
        case (funct3)
          3'b001: oOrigBULA = BULA_ZERO;
          3'b010: begin
            oOrigBULA   = BULA_CSR;
            oALUControl = ALU_OR;
          end
          3'b011: begin
            oOrigAULA   = AULA_NOT_A;
            oOrigBULA   = BULA_CSR;
            oALUControl = ALU_AND;
          end
          default: ;
        endcase
      end
      ST_CSR_WB: begin
        // rd gets the old CSR value on the same edge the CSR is rewritten
        oMem2Reg      = M2R_CSR;
        oRegWrite     = 1'b1;
        oCSRegWrite   = 1'b1;
        oInstrRetired = 1'b1;
      end
      ST_INVALID: oInvInstruction = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench: each issued instruction pushes its expected per-instruction
// trace; a monitor rebuilds the observed trace and compares on return to FETCH.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iInstr;
  logic [5:0]  oState;
  logic        oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack;
  logic [2:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC;
  logic        oIouD, oRegWrite, oCSRegWrite, oMemWrite, oMemRead;
  logic [4:0]  oALUControl;
  logic        oEcall, oInvInstruction, oInstrRetired;

  always #5 iCLK = ~iCLK;

  multi_cycle_control #(.P_HAS_M(1'b0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr), .oState(oState),
    .oEscreveIR(oEscreveIR), .oEscrevePC(oEscrevePC),
    .oEscrevePCCond(oEscrevePCCond), .oEscrevePCBack(oEscrevePCBack),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg),
    .oOrigPC(oOrigPC), .oIouD(oIouD), .oRegWrite(oRegWrite),
    .oCSRegWrite(oCSRegWrite), .oMemWrite(oMemWrite), .oMemRead(oMemRead),
    .oALUControl(oALUControl), .oEcall(oEcall),
    .oInvInstruction(oInvInstruction), .oInstrRetired(oInstrRetired)
  );

  typedef struct {
    logic [31:0] instr;
    int len;
    int path[8];
    int memread, memwrite, regwrite, csrwrite, pcwrite, pccond;
    int irwrite, retire, inv, ecall;
    int alu, aula, bula, orig, m2r;
  } trace_t;

  trace_t exp_q[$];
  trace_t obs;
  int     obs_retire_at;
  bit     active = 0;
  bit     mon_en = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [31:0] ins, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s instr=%08h got=%0d expected=%0d", name, ins, act, req);
    end
  endtask

  function automatic trace_t blank(input logic [31:0] ins);
    trace_t t;
    t.instr = ins; t.len = 0;
    foreach (t.path[i]) t.path[i] = -1;
    t.memread = 0; t.memwrite = 0; t.regwrite = 0; t.csrwrite = 0;
    t.pcwrite = 0; t.pccond = 0; t.irwrite = 0; t.retire = 0; t.inv = 0; t.ecall = 0;
    t.alu = -1; t.aula = -1; t.bula = -1; t.orig = -1; t.m2r = -1;
    return t;
  endfunction

  // Reference: expected trace of one instruction, derived from the ISA fields.
  function automatic trace_t model(input logic [31:0] ins);
    trace_t e;
    int base_ops[8];
    int seq[$];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [11:0] imm;
    bit bad = 0;
    base_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; imm = ins[31:20];
    e = blank(ins);
    e.memread = 1; e.irwrite = 1; e.pcwrite = 1;
    case (opc)
      7'h03: if (f3 == 3 || f3 == 6 || f3 == 7) bad = 1;
             else begin seq = '{2, 3, 4}; e.memread = 2; e.regwrite = 1; e.m2r = 2;
                        e.alu = ALU_ADD; e.aula = 0; e.bula = 2; end
      7'h23: if (f3 >= 3) bad = 1;
             else begin seq = '{2, 5}; e.memwrite = 1; e.alu = ALU_ADD; e.aula = 0; e.bula = 2; end
      7'h33: begin
        if (f7 == 7'h00) e.alu = base_ops[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
        else bad = 1;  // includes M-extension: this DUT is built without it
        if (!bad) begin seq = '{6, 7}; e.regwrite = 1; e.m2r = 0; e.aula = 0; e.bula = 0; end
      end
      7'h13: begin
        e.alu = base_ops[f3];
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 == 7'h20) e.alu = ALU_SRA;
        else if (f3 == 5 && f7 != 0) bad = 1;
        if (!bad) begin seq = '{8, 7}; e.regwrite = 1; e.m2r = 0; e.aula = 0; e.bula = 2; end
      end
      7'h37: begin seq = '{12, 7}; e.regwrite = 1; e.m2r = 0; e.alu = ALU_ADD; e.aula = 5; e.bula = 2; end
      7'h17: begin seq = '{7}; e.regwrite = 1; e.m2r = 0; end
      7'h63: if (f3 == 2 || f3 == 3) bad = 1;
             else begin seq = '{9}; e.pccond = 1; e.orig = 1; end
      7'h6F: begin seq = '{10}; e.regwrite = 1; e.m2r = 1; e.pcwrite = 2; e.orig = 1; end
      7'h67: begin seq = '{11}; e.regwrite = 1; e.m2r = 1; e.pcwrite = 2; e.orig = 2;
                   e.alu = ALU_ADD; e.aula = 0; e.bula = 2; end
      7'h0F: ;
      7'h73: begin
        if (f3 == 0 && imm == 0) begin seq = '{14}; e.ecall = 1; e.pcwrite = 2; e.orig = 3; end
        else if (f3 == 0 && imm == 2) begin seq = '{15}; e.pcwrite = 2; e.orig = 4; end
        else if (f3 >= 1 && f3 <= 3) begin
          seq = '{16, 17}; e.regwrite = 1; e.csrwrite = 1; e.m2r = 4;
          e.aula = (f3 == 3) ? 4 : 0;
          e.bula = (f3 == 1) ? 4 : 3;
          e.alu  = (f3 == 1) ? ALU_ADD : (f3 == 2) ? ALU_OR : ALU_AND;
        end else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad) begin
      seq = '{18}; e.inv = 1;
      e.alu = -1; e.aula = -1; e.bula = -1; e.regwrite = 0; e.m2r = -1;
    end else e.retire = 1;
    seq.push_front(1);
    seq.push_front(0);
    e.len = seq.size();
    foreach (seq[i]) e.path[i] = seq[i];
    return e;
  endfunction

  task automatic finalize();
    trace_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_instr instr=%08h got=trace expected=none", obs.instr);
      return;
    end
    e = exp_q.pop_front();
    check("latency", e.instr, obs.len, e.len);
    for (int i = 0; i < e.len && i < obs.len && i < 8; i++)
      check($sformatf("state[%0d]", i), e.instr, obs.path[i], e.path[i]);
    check("memread_cycles", e.instr, obs.memread, e.memread);
    check("memwrite_cycles", e.instr, obs.memwrite, e.memwrite);
    check("regwrite_cycles", e.instr, obs.regwrite, e.regwrite);
    check("csrwrite_cycles", e.instr, obs.csrwrite, e.csrwrite);
    check("pcwrite_cycles", e.instr, obs.pcwrite, e.pcwrite);
    check("pccond_cycles", e.instr, obs.pccond, e.pccond);
    check("irwrite_cycles", e.instr, obs.irwrite, e.irwrite);
    check("retire_pulses", e.instr, obs.retire, e.retire);
    check("invalid_pulses", e.instr, obs.inv, e.inv);
    check("ecall_pulses", e.instr, obs.ecall, e.ecall);
    check("exec_alu", e.instr, obs.alu, e.alu);
    check("exec_aula", e.instr, obs.aula, e.aula);
    check("exec_bula", e.instr, obs.bula, e.bula);
    check("orig_pc", e.instr, obs.orig, e.orig);
    check("mem2reg", e.instr, obs.m2r, e.m2r);
    if (e.retire == 1) check("retire_cycle", e.instr, obs_retire_at, e.len - 1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge iCLK);
      #1;
      if (!mon_en || iRST) begin
        active = 0;
        continue;
      end
      if (oState == 6'd0) begin
        if (active) finalize();
        obs = blank(iInstr);
        obs_retire_at = -1;
        active = 1;
      end
      if (active) begin
        if (obs.len < 8) obs.path[obs.len] = int'(oState);
        obs.memread  += int'(oMemRead);
        obs.memwrite += int'(oMemWrite);
        obs.regwrite += int'(oRegWrite);
        obs.csrwrite += int'(oCSRegWrite);
        obs.pcwrite  += int'(oEscrevePC);
        obs.pccond   += int'(oEscrevePCCond);
        obs.irwrite  += int'(oEscreveIR);
        obs.inv      += int'(oInvInstruction);
        obs.ecall    += int'(oEcall);
        if (oInstrRetired) begin
          obs.retire++;
          obs_retire_at = obs.len;
        end
        if (oState inside {6'd2, 6'd6, 6'd8, 6'd11, 6'd12, 6'd16} && obs.alu == -1) begin
          obs.alu  = int'(oALUControl);
          obs.aula = int'(oOrigAULA);
          obs.bula = int'(oOrigBULA);
        end
        if (oState != 6'd0 && (oEscrevePC || oEscrevePCCond)) obs.orig = int'(oOrigPC);
        if (oRegWrite) obs.m2r = int'(oMem2Reg);
        obs.len++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached with %0d instructions outstanding", exp_q.size());
    $fatal(1, "time limit");
  end

  task automatic wait_fetch(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge iCLK);
      if (oState == 6'd0) ok = 1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[11];
    logic [6:0] opc, f7;
    logic [31:0] ins;
    opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73};
    opc = (($urandom_range(0, 11)) == 11) ? 7'($urandom) : opcs[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    if (opc == 7'h73 && $urandom_range(0, 1) == 1) begin
      ins[14:12] = 3'b000;
      ins[31:20] = ($urandom_range(0, 2) == 0) ? 12'h000 :
                   ($urandom_range(0, 1) == 0) ? 12'h002 : 12'($urandom);
    end
    return ins;
  endfunction

  logic [31:0] stim[$];
  bit ok;

  initial begin : stimulus
    stim = '{32'h0002A303, 32'h002081B3, 32'h00208463, 32'h040332F3, 32'hFFFFFFFF,
             32'h02208133, 32'h00000073, 32'h00200073, 32'h0000000F, 32'h00000037,
             32'h00000017, 32'h0000006F, 32'h00008067, 32'h0020A023, 32'h00A00093};
    for (int i = 0; i < 300; i++) stim.push_back(rand_instr());

    iRST = 1'b1;
    iInstr = 32'h0;
    repeat (3) @(negedge iCLK);
    check("reset_state", 32'h0, int'(oState), 0);
    iRST = 1'b0;
    iInstr = 32'h0002A303;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge iCLK);
      if (oState == 6'd3) ok = 1;
    end
    check("reach_load_mem", iInstr, int'(ok), 1);
    #2 iRST = 1'b1;
    #1;
    check("async_reset_state", iInstr, int'(oState), 0);
    check("reset_memread", iInstr, int'(oMemRead), 1);
    check("reset_retire", iInstr, int'(oInstrRetired), 0);
    check("reset_iouD", iInstr, int'(oIouD), 0);
    @(negedge iCLK);
    check("held_reset_state", iInstr, int'(oState), 0);

    @(negedge iCLK);
    iRST = 1'b0;
    mon_en = 1;
    for (int k = 0; k < stim.size(); k++) begin
      if (k > 0) begin
        wait_fetch(ok);
        if (!ok) begin
          n_checks++; n_fail++;
          $display("FAIL fetch_timeout instr=%08h got=no_fetch expected=fetch", iInstr);
          break;
        end
      end
      iInstr = stim[k];
      exp_q.push_back(model(stim[k]));
    end
    wait_fetch(ok);
    #2;
    check("scoreboard_drained", 32'h0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
